mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer that shares one 32-bit word-wide memory port between the core's instruction-fetch path and its load/store path. It sits between the multicycle core and the unified memory. It serialises requests with fixed data-over-fetch priority and a starvation guard. It performs byte-lane steering and sign/zero extension for sub-word accesses, and rejects misaligned accesses without touching memory.

## Interface
- STARVE_LIMIT, 4: consecutive data grants allowed while fetch is pending before fetch is forced; range 1-15.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held high with stable i_addr until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle pulse: i_rdata/i_err valid.
- i_rdata  out  32  fetched word.
- i_err  out  1  with i_ack: i_addr[1:0] != 0.
- d_req  in  1  data request; d_* held stable until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- d_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_ack  out  1  one-cycle pulse: d_rdata/d_err valid.
- d_rdata  out  32  load result, extended to 32 bits; 0 for stores.
- d_err  out  1  with d_ack: misaligned or illegal size.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write enable.
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_wdata  out  32  lane-steered store data.
- mem_wstrb  out  4  byte strobes; 0000 on reads.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_ack  in  1  one-cycle completion; may arrive in the first mem_req cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE, no request: stay.
- IDLE, arbitration winner:
  - Data wins if d_req is set, unless starve_cnt == STARVE_LIMIT and i_req is set; then fetch wins.
  - Otherwise fetch wins if i_req is set.
- Error check on the winner, in IDLE:
  - Fetch errors if i_addr[1:0] != 0.
  - Data errors if d_size == 11, if half with d_addr[0] == 1, or if word with d_addr[1:0] != 0.
  - On error: go directly to DONE with the err output set. mem_req stays low.
- Good grant: latch the request and go to I_BUSY or D_BUSY. Set mem_req=1 and mem_addr={addr[31:2],2'b00}.
- Stores:
  - Byte: wdata = {4{d_wdata[7:0]}}, strobe 0001 << addr[1:0].
  - Half: wdata = {2{d_wdata[15:0]}}, strobe 0011 << addr[1:0].
  - Word: wdata = d_wdata, strobe 1111.
- I_BUSY/D_BUSY: hold all mem_* stable until mem_ack. On mem_ack, go to DONE, drop mem_req, and register the response:
  - Fetch: i_rdata = mem_rdata.
  - Load: d_rdata = selected byte or half, shifted down by addr[1:0]*8, then extended per d_unsigned.
  - Store: d_rdata = 0.
- DONE: pulse the granted ack (err registered alongside), then go to IDLE. No arbitration occurs in DONE.
- Requester rules:
  - The requester samples ack at the clock edge ending DONE.
  - On that same edge it drops req or presents a new request.
  - A req that is still high when IDLE is reached is treated as a new request.
- Starvation counter (4 bits):
  - Increments on each data grant made while i_req=1.
  - Clears on any fetch grant.
  - Clears on a data grant made while i_req=0.
  - Saturates at STARVE_LIMIT.
- Unhandled inputs:
  - mem_ack outside I_BUSY/D_BUSY is ignored.
  - Requester changes to addr/data while its request is in flight are ignored; latched values are used.

## Timing
- Reset (any state, including mid-transaction): state=IDLE, starve_cnt=0, and every output = 0 the next cycle. An in-flight memory access is abandoned. Memory must tolerate mem_req falling without mem_ack.
- Outputs are registered. There is no combinational path from the request inputs or mem_rdata to any output.
- Req sampled in IDLE at cycle 0:
  - mem_req high from cycle 1.
  - mem_ack at cycle k (k ≥ 1) gives ack at cycle k+1, and IDLE at k+2.
- Minimum turnaround is 3 cycles, with the next grant decided at cycle 3.
- Error response: req at cycle 0 gives ack+err at cycle 1, with no mem_req.
- Simultaneous i_req and d_req in IDLE: data is granted; fetch waits. Fetch is guaranteed service within STARVE_LIMIT+1 grants.

## Test plan
- Fetch, zero-wait memory: i_addr=0x100, memory returns 0x00000013 on the first mem_req cycle -> mem_addr=0x100 at cycle 1, i_ack and i_rdata=0x13 at cycle 2, i_err=0.
- Signed byte load: d_addr=0x203, d_size=00, d_unsigned=0, mem_rdata=0x80FFFFFF -> mem_addr=0x200, d_rdata=0xFFFFFF80. Repeat with d_unsigned=1 -> d_rdata=0x00000080.
- Half store: d_addr=0x402, d_wdata=0x1234ABCD -> mem_we=1, mem_wstrb=1100, mem_wdata=0xABCDABCD, and d_ack 1 cycle after mem_ack.
- Misaligned word load at 0x401 -> d_ack+d_err at cycle 1. mem_req never rises. d_size=11 gives the same result.
- Starvation, STARVE_LIMIT=4, i_req and d_req held continuously -> grant order D,D,D,D,I,D,...; starve_cnt returns to 0 after the I grant.
- Reset asserted while in D_BUSY with a 5-cycle-latency memory -> all outputs 0 the next cycle, no d_ack. A late mem_ack is ignored, and the next request is serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Fetch / load-store arbiter for a shared 32-bit memory port, with
//            starvation guard, byte-lane steering and sub-word extension.
// Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic        d_unsigned,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_I_BUSY = 2'd1;
    localparam logic [1:0] S_D_BUSY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam logic [3:0] c_limit  = 4'(STARVE_LIMIT);

    logic [1:0]  r_state, w_state_nxt;
    logic [3:0]  r_starve_cnt, w_starve_nxt;
    logic [1:0]  r_size, w_size_nxt;
    logic        r_unsigned, w_unsigned_nxt;
    logic [1:0]  r_addr_lo, w_addr_lo_nxt;

    logic        w_mem_req_nxt, w_mem_we_nxt;
    logic [31:0] w_mem_addr_nxt, w_mem_wdata_nxt;
    logic [3:0]  w_mem_wstrb_nxt;
    logic        w_i_ack_nxt, w_i_err_nxt, w_d_ack_nxt, w_d_err_nxt;
    logic [31:0] w_i_rdata_nxt, w_d_rdata_nxt;

    logic        w_d_win, w_d_bad;
    logic [31:0] w_st_wdata, w_load_val, w_lane;
    logic [3:0]  w_st_wstrb;

    // Data has priority unless fetch has been passed over STARVE_LIMIT times.
    assign w_d_win = d_req && !((r_starve_cnt == c_limit) && i_req);
    assign w_d_bad = (d_size == 2'b11) ||
                     ((d_size == 2'b01) && d_addr[0]) ||
                     ((d_size == 2'b10) && (d_addr[1:0] != 2'b00));

    always_comb begin
        w_st_wdata = d_wdata;
        w_st_wstrb = 4'b1111;
        case (d_size)
            2'b00: begin
                w_st_wdata = {4{d_wdata[7:0]}};
                w_st_wstrb = 4'b0001 << d_addr[1:0];
            end
            2'b01: begin
                w_st_wdata = {2{d_wdata[15:0]}};
                w_st_wstrb = 4'b0011 << d_addr[1:0];
            end
            default: ;
        endcase
    end

    // Selected lane is shifted down to bit 0, then extended.
    always_comb begin
        w_lane     = mem_rdata >> {r_addr_lo, 3'b000};
        w_load_val = w_lane;
        case (r_size)
            2'b00:   w_load_val = {{24{~r_unsigned & w_lane[7]}},  w_lane[7:0]};
            2'b01:   w_load_val = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve_cnt;
        w_size_nxt      = r_size;
        w_unsigned_nxt  = r_unsigned;
        w_addr_lo_nxt   = r_addr_lo;
        w_mem_req_nxt   = mem_req;
        w_mem_we_nxt    = mem_we;
        w_mem_addr_nxt  = mem_addr;
        w_mem_wdata_nxt = mem_wdata;
        w_mem_wstrb_nxt = mem_wstrb;
        w_i_ack_nxt     = 1'b0;
        w_i_err_nxt     = 1'b0;
        w_i_rdata_nxt   = i_rdata;
        w_d_ack_nxt     = 1'b0;
        w_d_err_nxt     = 1'b0;
        w_d_rdata_nxt   = d_rdata;
        case (r_state)
            S_IDLE: begin
                if (w_d_win) begin
                    if (!i_req)
                        w_starve_nxt = 4'd0;
                    else if (r_starve_cnt != c_limit)
                        w_starve_nxt = r_starve_cnt + 4'd1;
                    if (w_d_bad) begin
                        w_state_nxt   = S_DONE;
                        w_d_ack_nxt   = 1'b1;
                        w_d_err_nxt   = 1'b1;
                        w_d_rdata_nxt = 32'd0;
                    end else begin
                        w_state_nxt     = S_D_BUSY;
                        w_size_nxt      = d_size;
                        w_unsigned_nxt  = d_unsigned;
                        w_addr_lo_nxt   = d_addr[1:0];
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = d_we;
                        w_mem_addr_nxt  = {d_addr[31:2], 2'b00};
                        w_mem_wdata_nxt = d_we ? w_st_wdata : 32'd0;
                        w_mem_wstrb_nxt = d_we ? w_st_wstrb : 4'b0000;
                    end
                end else if (i_req) begin
                    w_starve_nxt = 4'd0;
                    if (i_addr[1:0] != 2'b00) begin
                        w_state_nxt   = S_DONE;
                        w_i_ack_nxt   = 1'b1;
                        w_i_err_nxt   = 1'b1;
                        w_i_rdata_nxt = 32'd0;
                    end else begin
                        w_state_nxt     = S_I_BUSY;
                        w_mem_req_nxt   = 1'b1;
                        w_mem_we_nxt    = 1'b0;
                        w_mem_addr_nxt  = {i_addr[31:2], 2'b00};
                        w_mem_wdata_nxt = 32'd0;
                        w_mem_wstrb_nxt = 4'b0000;
                    end
                end
            end
            S_I_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt     = S_DONE;
                    w_mem_req_nxt   = 1'b0;
                    w_i_ack_nxt     = 1'b1;
                    w_i_rdata_nxt   = mem_rdata;
                end
            end
            S_D_BUSY: begin
                if (mem_ack) begin
                    w_state_nxt     = S_DONE;
                    w_mem_req_nxt   = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_wstrb_nxt = 4'b0000;
                    w_d_ack_nxt     = 1'b1;
                    w_d_rdata_nxt   = mem_we ? 32'd0 : w_load_val;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_starve_cnt <= 4'd0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_wstrb    <= 4'b0000;
            i_ack        <= 1'b0;
            i_err        <= 1'b0;
            i_rdata      <= 32'd0;
            d_ack        <= 1'b0;
            d_err        <= 1'b0;
            d_rdata      <= 32'd0;
            busy         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_size       <= w_size_nxt;
            r_unsigned   <= w_unsigned_nxt;
            r_addr_lo    <= w_addr_lo_nxt;
            mem_req      <= w_mem_req_nxt;
            mem_we       <= w_mem_we_nxt;
            mem_addr     <= w_mem_addr_nxt;
            mem_wdata    <= w_mem_wdata_nxt;
            mem_wstrb    <= w_mem_wstrb_nxt;
            i_ack        <= w_i_ack_nxt;
            i_err        <= w_i_err_nxt;
            i_rdata      <= w_i_rdata_nxt;
            d_ack        <= w_d_ack_nxt;
            d_err        <= w_d_err_nxt;
            d_rdata      <= w_d_rdata_nxt;
            busy         <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Waits (bounded) for mem_req, answers it with one mem_ack cycle.
    task automatic mem_respond(input string tag, input logic [31:0] rdata);
        int t;
        t = 0;
        while (!mem_req && t < 12) begin
            step();
            t++;
        end
        check({tag, "_memreq"}, {31'd0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; i_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'd0; mem_ack = 1'b0;
        step(); step();
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_memreq",  {31'd0, mem_req}, 32'd0);
        check("rst_acks",    {30'd0, i_ack, d_ack}, 32'd0);
        check("rst_memaddr", mem_addr, 32'd0);
        rst = 1'b0;
        step();

        // Fetch with zero-wait memory
        i_req = 1'b1; i_addr = 32'h100;
        step();
        check("f_memreq",  {31'd0, mem_req}, 32'd1);
        check("f_memaddr", mem_addr, 32'h100);
        check("f_wstrb",   {28'd0, mem_wstrb}, 32'd0);
        check("f_busy",    {31'd0, busy}, 32'd1);
        check("f_ack_early", {31'd0, i_ack}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        step();
        mem_ack = 1'b0; i_req = 1'b0;
        check("f_ack",    {31'd0, i_ack}, 32'd1);
        check("f_rdata",  i_rdata, 32'h13);
        check("f_err",    {31'd0, i_err}, 32'd0);
        check("f_memreq_drop", {31'd0, mem_req}, 32'd0);
        step();
        check("f_ack_pulse", {31'd0, i_ack}, 32'd0);
        check("f_idle",      {31'd0, busy}, 32'd0);

        // Signed byte load, then the same request held as unsigned with a wait state
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0; d_addr = 32'h203;
        step();
        check("lb_memaddr", mem_addr, 32'h200);
        check("lb_we",      {31'd0, mem_we}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF_FFFF;
        step();
        mem_ack = 1'b0;
        check("lb_ack",   {31'd0, d_ack}, 32'd1);
        check("lb_rdata", d_rdata, 32'hFFFF_FF80);
        d_unsigned = 1'b1;
        step();
        check("lbu_idle_noack", {31'd0, d_ack}, 32'd0);
        step();
        check("lbu_memreq", {31'd0, mem_req}, 32'd1);
        d_unsigned = 1'b0;
        d_addr     = 32'h500;
        step();
        check("lbu_wait_memreq", {31'd0, mem_req}, 32'd1);
        check("lbu_wait_addr",   mem_addr, 32'h200);
        check("lbu_wait_noack",  {31'd0, d_ack}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF_FFFF;
        step();
        mem_ack = 1'b0; d_req = 1'b0;
        check("lbu_rdata", d_rdata, 32'h0000_0080);
        step();

        // Signed half load at offset 2, word load
        d_req = 1'b1; d_size = 2'b01; d_addr = 32'h602;
        mem_respond("lh", 32'h8001_1234);
        d_req = 1'b0;
        check("lh_rdata", d_rdata, 32'hFFFF_8001);
        step();
        d_req = 1'b1; d_size = 2'b10; d_addr = 32'h604;
        mem_respond("lw", 32'hDEAD_BEEF);
        d_req = 1'b0;
        check("lw_rdata", d_rdata, 32'hDEAD_BEEF);
        step();

        // Half store at 0x402, byte store at 0x401
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b01; d_addr = 32'h402; d_wdata = 32'h1234_ABCD;
        step();
        check("sh_we",    {31'd0, mem_we}, 32'd1);
        check("sh_wstrb", {28'd0, mem_wstrb}, 32'hC);
        check("sh_wdata", mem_wdata, 32'hABCD_ABCD);
        check("sh_addr",  mem_addr, 32'h400);
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0; d_req = 1'b0;
        check("sh_ack",   {31'd0, d_ack}, 32'd1);
        check("sh_rdata", d_rdata, 32'd0);
        step();
        d_req = 1'b1; d_size = 2'b00; d_addr = 32'h401;
        step();
        check("sb_wstrb", {28'd0, mem_wstrb}, 32'h2);
        check("sb_wdata", mem_wdata, 32'hCDCD_CDCD);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
        step();

        // Error responses
        d_req = 1'b1; d_size = 2'b10; d_addr = 32'h401;
        step();
        check("mis_ack",    {31'd0, d_ack}, 32'd1);
        check("mis_err",    {31'd0, d_err}, 32'd1);
        check("mis_memreq", {31'd0, mem_req}, 32'd0);
        d_req = 1'b0;
        step();
        check("mis_ack_pulse", {31'd0, d_ack}, 32'd0);
        d_req = 1'b1; d_size = 2'b11; d_addr = 32'h400;
        step();
        check("ill_ack_err", {30'd0, d_ack, d_err}, 32'd3);
        check("ill_memreq",  {31'd0, mem_req}, 32'd0);
        d_req = 1'b0;
        step();
        i_req = 1'b1; i_addr = 32'h102;
        step();
        check("fmis_ack_err", {30'd0, i_ack, i_err}, 32'd3);
        check("fmis_memreq",  {31'd0, mem_req}, 32'd0);
        i_req = 1'b0;
        step();

        // Starvation guard: D,D,D,D,I repeated
        i_req = 1'b1; i_addr = 32'h1000;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b10; d_addr = 32'h2000;
        for (int g = 0; g < 10; g++) begin
            mem_respond($sformatf("starve%0d", g), 32'h0);
            check($sformatf("starve_grant%0d", g), mem_addr,
                  ((g % 5) == 4) ? 32'h1000 : 32'h2000);
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
        check("starve_idle", {31'd0, busy}, 32'd0);

        // Reset during D_BUSY with slow memory, late mem_ack, then normal service
        d_req = 1'b1; d_addr = 32'h300;
        step();
        check("rd_memreq", {31'd0, mem_req}, 32'd1);
        step(); step();
        rst = 1'b1; d_req = 1'b0;
        step();
        rst = 1'b0;
        check("rd_memreq0", {31'd0, mem_req}, 32'd0);
        check("rd_busy0",   {31'd0, busy}, 32'd0);
        check("rd_addr0",   mem_addr, 32'd0);
        check("rd_dack0",   {31'd0, d_ack}, 32'd0);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        step();
        mem_ack = 1'b0;
        check("late_ack_dack", {31'd0, d_ack}, 32'd0);
        check("late_ack_busy", {31'd0, busy}, 32'd0);
        d_req = 1'b1; d_addr = 32'h304;
        mem_respond("post", 32'h1122_3344);
        d_req = 1'b0;
        check("post_ack",   {31'd0, d_ack}, 32'd1);
        check("post_rdata", d_rdata, 32'h1122_3344);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
